div_nnbit_s01_req_ctrl: RTL and testbench

Request/response front-end that sits directly upstream of the 01-bit absolute-value iterative divider (`div_nnbit_s01_abs_itera`). It buffers incoming divide requests in a small FIFO and resolves divide-by-zero and signed overflow locally, without starting the divider. All other requests are launched into the divider with a single-cycle start pulse, and the controller waits for completion. Each quotient/remainder is returned to the consumer over a valid/ready handshake, strictly in request order.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_req_fifo.sv | 60 ++++++
 rtl/div_nnbit_s01_req_ctrl.sv | 154 +++++++++++++++
 tb/tb_div_nnbit_s01_req_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider request front-end:
// controller FSM states and the buffered request record.
package div_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_TW = 4;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              sgn;
        logic [DIV_DW-1:0] x;
        logic [DIV_DW-1:0] y;
        logic [DIV_TW-1:0] tag;
    } req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Show-ahead synchronous request FIFO with a registered full flag.
// Pushes are refused while full, even when a pop happens in the same cycle.
module div_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_n = count;
        unique case ({do_push, do_pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
        end
    end

    // Storage carries no reset; entries are only read when valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/div_nnbit_s01_req_ctrl.sv
// Request front-end for the iterative divider: buffers requests, bypasses
// divide-by-zero and signed overflow, and returns results in order.
module div_nnbit_s01_req_ctrl
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = DIV_TW
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_signed,
    input  logic [DATA_WIDTH-1:0] i_req_x,
    input  logic [DATA_WIDTH-1:0] i_req_y,
    input  logic [TAG_WIDTH-1:0]  i_req_tag,
    output logic                  o_div_valid,
    output logic                  o_div_signed,
    output logic [DATA_WIDTH-1:0] o_div_x,
    output logic [DATA_WIDTH-1:0] o_div_y,
    input  logic [DATA_WIDTH-1:0] i_div_res,
    input  logic [DATA_WIDTH-1:0] i_div_rem,
    input  logic                  i_div_valid,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_res,
    output logic [DATA_WIDTH-1:0] o_rsp_rem,
    output logic [TAG_WIDTH-1:0]  o_rsp_tag,
    output logic                  o_rsp_bypass,
    output logic                  o_busy
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t state;
    state_t state_n;

    req_t req_in;
    req_t head;
    req_t op;

    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  capture;
    logic                  is_dbz;
    logic                  is_ovf;
    logic [DATA_WIDTH-1:0] res_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic                  byp_q;

    assign req_in = '{
        sgn: i_req_signed,
        x:   i_req_x,
        y:   i_req_y,
        tag: i_req_tag
    };

    div_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_req_valid),
        .pop   (pop),
        .wdata (req_in),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // y == all-ones is never zero, so the two bypass cases are exclusive.
    assign is_dbz = (head.y == '0);
    assign is_ovf = head.sgn && (head.x == MIN_NEG) && (head.y == '1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        capture     = 1'b0;
        o_div_valid = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = (is_dbz || is_ovf) ? RESP : LAUNCH;
                end
            end
            LAUNCH: begin
                o_div_valid = 1'b1;
                state_n     = WAIT;
            end
            WAIT: begin
                if (i_div_valid) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op    <= '0;
            res_q <= '0;
            rem_q <= '0;
            byp_q <= 1'b0;
        end else if (pop) begin
            op    <= head;
            byp_q <= is_dbz || is_ovf;
            unique case (1'b1)
                is_dbz: begin
                    res_q <= '1;
                    rem_q <= head.x;
                end
                is_ovf: begin
                    res_q <= head.x;
                    rem_q <= '0;
                end
                default: begin
                    res_q <= res_q;
                    rem_q <= rem_q;
                end
            endcase
        end else if (capture) begin
            res_q <= i_div_res;
            rem_q <= i_div_rem;
        end
    end

    assign o_req_ready  = !full;
    assign o_div_signed = op.sgn;
    assign o_div_x      = op.x;
    assign o_div_y      = op.y;
    assign o_rsp_res    = res_q;
    assign o_rsp_rem    = rem_q;
    assign o_rsp_tag    = op.tag;
    assign o_rsp_bypass = byp_q;
    assign o_busy       = !empty || (state != IDLE);

endmodule

// File: tb/tb_div_nnbit_s01_req_ctrl.sv
// Directed bench for the divider request front-end with a
// variable-latency stand-in for the iterative divider.
module tb_div_nnbit_s01_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_signed;
    logic [7:0] req_x;
    logic [7:0] req_y;
    logic [3:0] req_tag;
    logic       div_valid;
    logic       div_signed;
    logic [7:0] div_x;
    logic [7:0] div_y;
    logic [7:0] div_res;
    logic [7:0] div_rem;
    logic       div_done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_res;
    logic [7:0] rsp_rem;
    logic [3:0] rsp_tag;
    logic       rsp_bypass;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int div_lat = 4;

    always #5 clk = ~clk;

    div_nnbit_s01_req_ctrl #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .TAG_WIDTH  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_signed (req_signed),
        .i_req_x      (req_x),
        .i_req_y      (req_y),
        .i_req_tag    (req_tag),
        .o_div_valid  (div_valid),
        .o_div_signed (div_signed),
        .o_div_x      (div_x),
        .o_div_y      (div_y),
        .i_div_res    (div_res),
        .i_div_rem    (div_rem),
        .i_div_valid  (div_done),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_res    (rsp_res),
        .o_rsp_rem    (rsp_rem),
        .o_rsp_tag    (rsp_tag),
        .o_rsp_bypass (rsp_bypass),
        .o_busy       (busy)
    );

    // Divider stand-in: latches operands on the start pulse,
    // answers div_lat cycles later with a one-cycle done.
    function automatic logic [15:0] ref_div(
        input logic s, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] q;
        logic [7:0] r;
        if (s) begin
            q = 8'($signed(x) / $signed(y));
            r = 8'($signed(x) % $signed(y));
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r};
    endfunction

    logic        m_busy;
    int          m_cnt;
    logic [15:0] m_qr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_qr     <= '0;
            div_done <= 1'b0;
            div_res  <= '0;
            div_rem  <= '0;
        end else begin
            div_done <= 1'b0;
            if (div_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= div_lat;
                m_qr   <= ref_div(div_signed, div_x, div_y);
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_busy   <= 1'b0;
                    div_done <= 1'b1;
                    div_res  <= m_qr[15:8];
                    div_rem  <= m_qr[7:0];
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (div_valid) pulses <= pulses + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the response accepted.
    task automatic run_one(input string nm, input logic s,
                           input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] tg, input logic [7:0] er,
                           input logic [7:0] em, input logic eb);
        int p0;
        int n;
        p0 = pulses;
        req_valid  = 1'b1;
        req_signed = s;
        req_x      = x;
        req_y      = y;
        req_tag    = tg;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (eb) begin
            chk({nm, "_early"}, 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk({nm, "_t1"}, 32'(rsp_valid), 32'd1);
        end else begin
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk({nm, "_vld"}, 32'(rsp_valid), 32'd1);
            chk({nm, "_opx"}, 32'(div_x), 32'(x));
        end
        chk({nm, "_res"}, 32'(rsp_res), 32'(er));
        chk({nm, "_rem"}, 32'(rsp_rem), 32'(em));
        chk({nm, "_tag"}, 32'(rsp_tag), 32'(tg));
        chk({nm, "_byp"}, 32'(rsp_bypass), 32'(eb));
        chk({nm, "_pulses"}, 32'(pulses - p0), eb ? 32'd0 : 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    logic [7:0] bp_rem [5] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    initial begin
        int n;
        logic seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_tag    = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_div_valid", 32'(div_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", {div_x, div_y, rsp_res, rsp_rem}, 32'd0);
        chk("rst_tag_byp", {rsp_tag, rsp_bypass}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_one("sdiv", 1'b1, 8'h95, 8'h1D, 4'h1,
                8'hFD, 8'hEC, 1'b0);
        run_one("udiv", 1'b0, 8'h95, 8'h1D, 4'h2,
                8'h05, 8'h04, 1'b0);
        run_one("dbz_u", 1'b0, 8'h37, 8'h00, 4'h3,
                8'hFF, 8'h37, 1'b1);
        run_one("dbz_s", 1'b1, 8'h37, 8'h00, 4'h4,
                8'hFF, 8'h37, 1'b1);
        run_one("ovf_s", 1'b1, 8'h80, 8'hFF, 4'h5,
                8'h80, 8'h00, 1'b1);
        div_lat = 1;
        run_one("ovf_u", 1'b0, 8'h80, 8'hFF, 4'h6,
                8'h00, 8'h80, 1'b0);
        div_lat = 4;

        // Backpressure: five pushes, one in flight plus four buffered.
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_pre", 32'(req_ready), 32'd1);
            req_valid  = 1'b1;
            req_signed = 1'b0;
            req_x      = 8'(100 + i);
            req_y      = 8'd7;
            req_tag    = 4'(i);
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_full", 32'(req_ready), 32'd0);
        req_tag = 4'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_still_full", 32'(req_ready), 32'd0);

        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            repeat (3) begin
                chk("bp_tag", 32'(rsp_tag), 32'(i));
                chk("bp_res", 32'(rsp_res), 32'd14);
                chk("bp_rem", 32'(rsp_rem), 32'(bp_rem[i]));
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        seen = 1'b0;
        repeat (30) begin
            seen |= rsp_valid;
            @(negedge clk);
        end
        chk("bp_no_extra", 32'(seen), 32'd0);
        chk("bp_drained", {req_ready, busy}, 32'h2);

        // Reset while the divider is busy with one more request queued.
        div_lat    = 20;
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_x      = 8'h64;
        req_y      = 8'h07;
        req_tag    = 4'h9;
        n = pulses;
        @(posedge clk);
        @(negedge clk);
        req_tag = 4'hA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (pulses == n && pulses < n + 2 && checks < 100000) begin
            @(negedge clk);
            if (pulses == n) begin
                n = n;
            end
            break;
        end
        repeat (3) @(negedge clk);
        chk("rw_started", 32'(pulses - n), 32'd1);
        chk("rw_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_div_valid", 32'(div_valid), 32'd0);
        chk("rw_ready_busy", {req_ready, busy}, 32'h2);
        chk("rw_data", {div_x, rsp_res, rsp_rem, 4'h0, rsp_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= rsp_valid | div_valid | busy;
        end
        chk("rw_no_resp", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
